// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults, write-lane bundle and lane-priority resolver
package regfile_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH = 8;
  localparam int LANE_ADDR_W = 16;
  localparam int LANE_DATA_W = 64;
  typedef struct packed {
    logic we;
    logic [LANE_ADDR_W-1:0] addr;
    logic [LANE_DATA_W-1:0] data;
  } lane_t;
  function automatic logic [LANE_DATA_W-1:0] lane_pick(lane_t l0, lane_t l1, logic [LANE_ADDR_W-1:0] a,
                                                       logic [LANE_DATA_W-1:0] arr);
    return (l1.we && l1.addr == a) ? l1.data : (l0.we && l0.addr == a) ? l0.data : arr;
  endfunction
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-entry busy bits with reserve/clear and registered busy count
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter bit ZERO_REG = 1'b0,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we0,
  input  logic [ADDR_W-1:0] waddr0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] waddr1,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic              rbusy1,
  output logic              rbusy2,
  output logic [ADDR_W:0]   busy_cnt
);
  logic [DEPTH-1:0] busy, busy_nxt;
  logic [ADDR_W:0] cnt_nxt;
  always_comb begin
    busy_nxt = busy;
    cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      busy_nxt[i] = ((we0 && waddr0 == ADDR_W'(i)) || (we1 && waddr1 == ADDR_W'(i))) ? 1'b0 : busy[i];
      // a new reservation supersedes a same-cycle completing write
      busy_nxt[i] = (rsv_en && rsv_addr == ADDR_W'(i) && !(ZERO_REG && i == 0)) ? 1'b1 : busy_nxt[i];
      cnt_nxt = cnt_nxt + (ADDR_W+1)'(busy_nxt[i]);
    end
  end
  always_ff @(posedge clk) begin
    busy <= rst ? '0 : busy_nxt;
    busy_cnt <= rst ? '0 : cnt_nxt;
  end
  assign rbusy1 = busy[raddr1] & ~((we0 && waddr0 == raddr1) || (we1 && waddr1 == raddr1));
  assign rbusy2 = busy[raddr2] & ~((we0 && waddr0 == raddr2) || (we1 && waddr1 == raddr2));
endmodule

// File: rtl/regfile_2w2r_sb.sv
// regfile_2w2r_sb: 2-write/2-read register file with write bypass and busy scoreboard
module regfile_2w2r_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter bit ZERO_REG = 1'b0,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we0,
  input  logic [ADDR_W-1:0] waddr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] waddr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  output logic              rbusy1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  output logic              rbusy2,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic [ADDR_W:0]   busy_cnt
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic ew0, ew1;
  lane_t lane0, lane1;
  // effective enables: no writes under reset, none to a hardwired zero entry
  assign ew0 = we0 & ~rst & ~(ZERO_REG & (waddr0 == '0));
  assign ew1 = we1 & ~rst & ~(ZERO_REG & (waddr1 == '0));
  assign lane0 = '{we: ew0, addr: LANE_ADDR_W'(waddr0), data: LANE_DATA_W'(wdata0)};
  assign lane1 = '{we: ew1, addr: LANE_ADDR_W'(waddr1), data: LANE_DATA_W'(wdata1)};
  always_ff @(posedge clk)
    for (int i = 0; i < DEPTH; i++)
      mem[i] <= rst ? '0 : DATA_W'(lane_pick(lane0, lane1, LANE_ADDR_W'(i), LANE_DATA_W'(mem[i])));
  assign rdata1 = (ZERO_REG && raddr1 == '0) ? '0
                : DATA_W'(lane_pick(lane0, lane1, LANE_ADDR_W'(raddr1), LANE_DATA_W'(mem[raddr1])));
  assign rdata2 = (ZERO_REG && raddr2 == '0) ? '0
                : DATA_W'(lane_pick(lane0, lane1, LANE_ADDR_W'(raddr2), LANE_DATA_W'(mem[raddr2])));
  regfile_scoreboard #(.DEPTH(DEPTH), .ZERO_REG(ZERO_REG)) u_sb (
    .clk(clk), .rst(rst),
    .we0(ew0), .waddr0(waddr0), .we1(ew1), .waddr1(waddr1),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .raddr1(raddr1), .raddr2(raddr2),
    .rbusy1(rbusy1), .rbusy2(rbusy2), .busy_cnt(busy_cnt)
  );
endmodule

// File: tb/tb_regfile_2w2r_sb.sv
// tb_regfile_2w2r_sb: random + directed check of both ZERO_REG variants against a reference model
module tb_regfile_2w2r_sb;
  logic clk = 1'b0, rst = 1'b1;
  logic we0 = 1'b0, we1 = 1'b0, rsv_en = 1'b0;
  logic [2:0] waddr0 = '0, waddr1 = '0, raddr1 = '0, raddr2 = '0, rsv_addr = '0;
  logic [7:0] wdata0 = '0, wdata1 = '0;
  logic [1:0][7:0] rd1, rd2;
  logic [1:0] rb1, rb2;
  logic [1:0][3:0] cnt;
  int total = 0, bad = 0;
  int m [2][8];
  bit b [2][8];
  always #5 clk = ~clk;
  for (genvar z = 0; z < 2; z++) begin : g_dut
    regfile_2w2r_sb #(.DATA_W(8), .DEPTH(8), .ZERO_REG(z)) dut (
      .clk(clk), .rst(rst),
      .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
      .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
      .raddr1(raddr1), .rdata1(rd1[z]), .rbusy1(rb1[z]),
      .raddr2(raddr2), .rdata2(rd2[z]), .rbusy2(rb2[z]),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_cnt(cnt[z])
    );
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  function automatic int exp_rd(int z, int a);
    if (z == 1 && a == 0) return 0;
    if (!rst && we1 && waddr1 == a) return wdata1;
    if (!rst && we0 && waddr0 == a) return wdata0;
    return m[z][a];
  endfunction
  function automatic int exp_busy(int z, int a);
    if (!rst && ((we1 && waddr1 == a) || (we0 && waddr0 == a))) return 0;
    return b[z][a];
  endfunction
  function automatic int exp_cnt(int z);
    int n = 0;
    for (int i = 0; i < 8; i++) n += b[z][i];
    return n;
  endfunction
  task automatic upd();
    for (int z = 0; z < 2; z++) begin
      if (rst) begin
        for (int i = 0; i < 8; i++) begin
          m[z][i] = 0;
          b[z][i] = 0;
        end
      end else begin
        if (we0 && !(z == 1 && waddr0 == 0)) m[z][waddr0] = wdata0;
        if (we1 && !(z == 1 && waddr1 == 0)) m[z][waddr1] = wdata1;
        if (we0) b[z][waddr0] = 0;
        if (we1) b[z][waddr1] = 0;
        if (rsv_en && !(z == 1 && rsv_addr == 0)) b[z][rsv_addr] = 1;
      end
    end
  endtask
  task automatic settle();
    #2;
    for (int z = 0; z < 2; z++) begin
      chk(z ? "z_rdata1" : "rdata1", 32'(rd1[z]), exp_rd(z, raddr1));
      chk(z ? "z_rdata2" : "rdata2", 32'(rd2[z]), exp_rd(z, raddr2));
      chk(z ? "z_rbusy1" : "rbusy1", 32'(rb1[z]), exp_busy(z, raddr1));
      chk(z ? "z_rbusy2" : "rbusy2", 32'(rb2[z]), exp_busy(z, raddr2));
      chk(z ? "z_busy_cnt" : "busy_cnt", 32'(cnt[z]), exp_cnt(z));
    end
  endtask
  task automatic tick();
    @(posedge clk);
    upd();
    #1;
  endtask
  task automatic step();
    settle();
    tick();
  endtask
  task automatic idle();
    we0 = 1'b0;
    we1 = 1'b0;
    rsv_en = 1'b0;
  endtask
  task automatic rnd_in();
    we0 = 1'($urandom);
    we1 = 1'($urandom);
    waddr0 = 3'($urandom);
    waddr1 = 3'($urandom);
    wdata0 = 8'($urandom);
    wdata1 = 8'($urandom);
    raddr1 = 3'($urandom);
    raddr2 = 3'($urandom);
    rsv_en = 1'($urandom);
    rsv_addr = 3'($urandom);
  endtask
  initial begin
    tick();
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rnd_in();
      rsv_en = 1'b0;
      step();
    end
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rnd_in();
      step();
    end
    rst = 1'b0;
    idle();
    for (int i = 0; i < 8; i++) begin
      raddr1 = 3'(i);
      raddr2 = 3'(i);
      settle();
      chk("rst_rdata", 32'(rd1[0]), 0);
      chk("rst_rbusy", 32'(rb1[0]), 0);
      chk("rst_cnt", 32'(cnt[0]), 0);
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      we0 = 1'b1;
      waddr0 = 3'(i);
      wdata0 = 8'(i + 10);
      step();
    end
    idle();
    for (int i = 0; i < 8; i++) begin
      raddr1 = 3'(i);
      raddr2 = 3'(7 - i);
      settle();
      chk("fill_rd1", 32'(rd1[0]), i + 10);
      chk("fill_rd2", 32'(rd2[0]), 17 - i);
      tick();
    end
    we0 = 1'b1; waddr0 = 3'd3; wdata0 = 8'hAA;
    we1 = 1'b1; waddr1 = 3'd3; wdata1 = 8'h55;
    raddr1 = 3'd3;
    settle();
    chk("conf_bypass", 32'(rd1[0]), 32'h55);
    tick();
    idle();
    settle();
    chk("conf_store", 32'(rd1[0]), 32'h55);
    tick();
    we0 = 1'b1; waddr0 = 3'd5; wdata0 = 8'h0F;
    step();
    wdata0 = 8'h3C; raddr2 = 3'd5;
    settle();
    chk("bypass_rd2", 32'(rd2[0]), 32'h3C);
    tick();
    idle();
    rsv_en = 1'b1; rsv_addr = 3'd2;
    step();
    rsv_addr = 3'd4;
    settle();
    chk("sb_cnt1", 32'(cnt[0]), 1);
    tick();
    idle();
    we0 = 1'b1; waddr0 = 3'd2; wdata0 = 8'h21; raddr1 = 3'd2;
    settle();
    chk("sb_cnt2", 32'(cnt[0]), 2);
    chk("sb_wr_clears_stall", 32'(rb1[0]), 0);
    tick();
    idle();
    raddr1 = 3'd4;
    settle();
    chk("sb_cnt_after_wr", 32'(cnt[0]), 1);
    chk("sb_busy4", 32'(rb1[0]), 1);
    tick();
    rsv_en = 1'b1; rsv_addr = 3'd4;
    we1 = 1'b1; waddr1 = 3'd4; wdata1 = 8'h44;
    step();
    idle();
    settle();
    chk("sb_rsv_wins", 32'(rb1[0]), 1);
    chk("sb_cnt_keep", 32'(cnt[0]), 1);
    tick();
    we0 = 1'b1; waddr0 = 3'd0; wdata0 = 8'h77;
    rsv_en = 1'b1; rsv_addr = 3'd0;
    raddr1 = 3'd0;
    settle();
    chk("z_rd0_now", 32'(rd1[1]), 0);
    chk("z_busy0_now", 32'(rb1[1]), 0);
    tick();
    idle();
    settle();
    chk("z_rd0_after", 32'(rd1[1]), 0);
    chk("z_busy0_after", 32'(rb1[1]), 0);
    chk("z_cnt_unchanged", 32'(cnt[1]), 1);
    tick();
    rsv_en = 1'b1; rsv_addr = 3'd1;
    step();
    rsv_addr = 3'd6;
    step();
    idle();
    settle();
    chk("pre_rst_cnt", 32'(cnt[1]), 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    chk("rst_mid_cnt", 32'(cnt[0]), 0);
    chk("z_rst_mid_cnt", 32'(cnt[1]), 0);
    tick();
    for (int i = 0; i < 400; i++) begin
      rnd_in();
      rst = ($urandom_range(31) == 0);
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regfile_2w2r_sb.md
Name: regfile_2w2r_sb

Overview:
- Parametrised successor to the team's 8x8 single-write register file.
- Provides DEPTH entries of DATA_W bits, two write ports with fixed priority, and two combinational read ports with same-cycle write-to-read bypass.
- An optional hardwired-zero entry 0 is supported.
- A per-entry busy scoreboard (reserve/clear) is built in, so an issue stage can stall on pending producers.
- Sits between decode (read/reserve) and writeback (two write lanes) in the datapath.

Parameters:
- DATA_W, 8, width of each entry.
- DEPTH, 8, number of entries; power of two, minimum 2.
- ADDR_W, $clog2(DEPTH), address width; derived, not overridden.
- ZERO_REG, 0, when 1 entry 0 always reads 0, ignores writes and never becomes busy.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- we0  in  1  write enable, lane 0.
- waddr0  in  ADDR_W  write address, lane 0.
- wdata0  in  DATA_W  write data, lane 0.
- we1  in  1  write enable, lane 1 (higher priority).
- waddr1  in  ADDR_W  write address, lane 1.
- wdata1  in  DATA_W  write data, lane 1.
- raddr1  in  ADDR_W  read address, port 1.
- rdata1  out  DATA_W  read data, port 1 (combinational).
- rbusy1  out  1  entry at raddr1 has a pending producer.
- raddr2  in  ADDR_W  read address, port 2.
- rdata2  out  DATA_W  read data, port 2 (combinational).
- rbusy2  out  1  entry at raddr2 has a pending producer.
- rsv_en  in  1  reserve request: mark entry busy.
- rsv_addr  in  ADDR_W  entry to reserve.
- busy_cnt  out  ADDR_W+1  number of busy entries (registered).

Behaviour:
- Reset (rst=1 at a rising edge):
  - All entries become 0, all busy bits 0, busy_cnt = 0.
  - While rst is high, writes and reserves are ignored and bypass is suppressed: rdataN = stored array value, rbusyN = stored busy bit.
  - Reset mid-operation discards every outstanding reservation and any same-cycle write.
- Write:
  - At the rising edge, an enabled lane writes its data to its address.
  - If we0 and we1 target the same address, lane 1 wins and lane 0 is dropped for that address.
  - Writes to different addresses both commit.
  - ZERO_REG=1 with address 0: the write is discarded.
- Read:
  - Purely combinational, with zero-cycle latency from the address.
  - Bypass priority: lane 1 write hit, then lane 0 write hit, then array.
  - A write in the current cycle to raddrN makes rdataN show the new data in the same cycle.
  - With ZERO_REG=1, raddrN=0 gives rdataN=0 regardless of bypass.
- Scoreboard:
  - A busy bit is set at the edge where rsv_en=1 for that entry.
  - It is cleared at the edge where any enabled write hits that entry.
  - Reserve and write to the same entry in the same cycle: the reserve wins and the bit stays or becomes 1, since a new producer supersedes.
  - Reserving an already-busy entry keeps it at 1 with no count change.
  - rbusyN = busy[raddrN] AND NOT (a write hits raddrN this cycle). Bypass clears the stall in the same cycle the data arrives.
  - ZERO_REG=1: entry 0 busy is always 0 and reserves to it are ignored.
- busy_cnt:
  - Registered population count of the busy bits, updated at the same edge as the bits.
  - Range is 0..DEPTH; it cannot wrap because the width is ADDR_W+1.
- Wrap-around: addresses are full-range ADDR_W; no out-of-range case exists.

Decomposition:
- Package regfile_pkg holds:
  - the default DATA_W/DEPTH localparams;
  - a typedef for the write-lane bundle {we, addr, data};
  - a function resolving lane priority for a given address (shared by the array write and the bypass muxes).
- Sub-module regfile_scoreboard holds the busy-bit vector, the set/clear/priority logic and the busy_cnt register. The top level instantiates it alongside the data array.

Test Plan:
- Reset with defaults: hold rst 2 cycles after random writes -> all rdata=0, rbusy=0, busy_cnt=0; writes during rst have no effect.
- Write entries 0..7 with i+10 via lane 0, then read raddr1=i, raddr2=7-i -> rdata1=i+10, rdata2=17-i.
- Same-cycle conflict: we0 addr3 data 0xAA and we1 addr3 data 0x55 -> same-cycle rdata1(raddr1=3)=0x55, and the stored value is 0x55 afterwards.
- Bypass: entry 5 holds 0x0F; in one cycle we0 addr5 data 0x3C with raddr2=5 -> rdata2=0x3C in that cycle (not 0x0F).
- Scoreboard: reserve 2, then 4 -> busy_cnt 1, then 2. Write addr2 -> rbusy1(raddr1=2)=0 in the write cycle and busy_cnt=1 next. Reserve 4 plus write addr4 in one cycle -> entry 4 stays busy.
- ZERO_REG=1 instance: write 0x77 to addr0 and rsv addr0 -> rdata=0, rbusy=0, busy_cnt unchanged; rst mid-reservation (entries 1, 6 busy) -> busy_cnt=0 after the edge.
